// File: rtl/online_digit_collector_if.sv
// Digit-in / word-out handshake bundle for online_digit_collector.
// The slave modport is the collector; the master modport is its environment.
interface online_digit_collector_if #(
    parameter int NDIGITS = 8
);
    logic [1:0]       x;
    logic             In_vld;
    logic             In_rdy;
    logic [NDIGITS:0] res;
    logic             Out_vld;
    logic             Out_rdy;

    modport master (output x, In_vld, Out_rdy, input In_rdy, res, Out_vld);
    modport slave  (input x, In_vld, Out_rdy, output In_rdy, res, Out_vld);
endinterface

// File: rtl/online_digit_collector.sv
// On-the-fly (Q/QM) conversion of MSD-first radix-2 signed digits into NDIGITS+1-bit words.
// Optional ONLINE_DELAY_SKIP_EN: the first DELTA digits of each word are accepted but not converted.
module online_digit_collector #(
    parameter int NDIGITS = 8,
    parameter int DELTA   = 2
) (
    input logic                     clk,
    input logic                     rst,
    online_digit_collector_if.slave bus
);
    localparam int W  = NDIGITS + 1;
    localparam int CW = $clog2(NDIGITS + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

    if (NDIGITS < 2 || DELTA < 0 || DELTA >= NDIGITS) begin : g_bad_cfg
        $error("online_digit_collector: need NDIGITS >= 2 and 0 <= DELTA < NDIGITS");
    end

    typedef enum logic {ACCUM, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   q, qm, res_r;
    logic [W-1:0]   q_nx, qm_nx, res_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           accept, conv, pos, neg;

    // {d_plus, d_minus}: 10 = +1, 01 = -1, 00/11 = 0
    assign pos    = (bus.x == 2'b10);
    assign neg    = (bus.x == 2'b01);
    assign accept = bus.In_vld && (state == ACCUM);

`ifdef ONLINE_DELAY_SKIP_EN
    localparam logic [CW-1:0] SKIP = CW'(DELTA);
    assign conv = accept && (cnt >= SKIP);
`else
    assign conv = accept;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            cnt   <= '0;
            q     <= '0;
            qm    <= '1;
            res_r <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            q     <= q_nx;
            qm    <= qm_nx;
            res_r <= res_nx;
        end
    end

    // Appending a digit never needs a carry: both candidates are kept and one is
    // selected, so QM = Q - 1 holds after every step (mod 2^W, which also sign-extends).
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        q_nx     = q;
        qm_nx    = qm;
        res_nx   = res_r;
        case (state)
            ACCUM: begin
                if (accept) begin
                    cnt_nx = cnt + CW'(1);
                    if (conv) begin
                        if (pos) begin
                            q_nx  = {q[W-2:0], 1'b1};
                            qm_nx = {q[W-2:0], 1'b0};
                        end else if (neg) begin
                            q_nx  = {qm[W-2:0], 1'b1};
                            qm_nx = {qm[W-2:0], 1'b0};
                        end else begin
                            q_nx  = {q[W-2:0], 1'b0};
                            qm_nx = {qm[W-2:0], 1'b1};
                        end
                    end
                    if (cnt == LAST) begin
                        res_nx   = q_nx;
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.Out_rdy) begin
                    state_nx = ACCUM;
                    cnt_nx   = '0;
                    q_nx     = '0;
                    qm_nx    = '1;
                end
            end
            default: state_nx = ACCUM;
        endcase
    end

    assign bus.In_rdy  = (state == ACCUM);
    assign bus.Out_vld = (state == DONE);
    assign bus.res     = res_r;
endmodule

// File: tb/tb_online_digit_collector.sv
// Randomized scoreboard bench for online_digit_collector (NDIGITS = 4, DELTA = 2).
module tb_online_digit_collector;
    localparam int ND    = 4;
    localparam int DELTA = 2;
    localparam int W     = ND + 1;
`ifdef ONLINE_DELAY_SKIP_EN
    localparam int SKIP = DELTA;
`else
    localparam int SKIP = 0;
`endif

    typedef int arr4_t[4];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    online_digit_collector_if #(.NDIGITS(ND)) bus();
    online_digit_collector #(.NDIGITS(ND), .DELTA(DELTA)) dut (.clk(clk), .rst(rst), .bus(bus));

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] expq[$];
    int           stall_n  = 0;
    bit           started  = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Digit codes used by the bench: -1, 0 (sent as 00), +1, 2 (zero sent as 11).
    function automatic logic [1:0] enc(input int d);
        case (d)
            1:       return 2'b10;
            -1:      return 2'b01;
            2:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Word value = sum of converted digits weighted MSD-first, reduced to W bits.
    function automatic logic [W-1:0] model(input arr4_t d);
        int v = 0;
        for (int i = 0; i < ND; i++)
            if (i >= SKIP) v = 2 * v + ((d[i] == 2) ? 0 : d[i]);
        return W'(v);
    endfunction

    // Entered and left at posedge+1.
    task automatic send_digit(input int d, input int gap);
        int n;
        repeat (gap) begin
            bus.In_vld = 1'b0;
            bus.x      = 2'($urandom);
            @(posedge clk); #1;
        end
        bus.In_vld = 1'b1;
        bus.x      = enc(d);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.In_rdy && n < 50);
        if (!bus.In_rdy) begin
            checks++;
            failures++;
            $display("FAIL in_rdy_timeout: got In_rdy=0 for %0d cycles expected 1", n);
        end
        @(posedge clk); #1;
        bus.In_vld = 1'b0;
    endtask

    task automatic send_word(input arr4_t d, input arr4_t g, input int stall);
        for (int i = 0; i < ND; i++) begin
            send_digit(d[i], g[i]);
            if (i == 0) stall_n = stall;
        end
        expq.push_back(model(d));
        bus.In_vld = 1'($urandom);
        bus.x      = 2'($urandom);
        @(negedge clk);
        check("out_latency", W'(bus.Out_vld), W'(1));
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        bus.In_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_rdy", W'(bus.In_rdy), W'(1));
        check("rst_out_vld", W'(bus.Out_vld), W'(0));
        check("rst_res", bus.res, W'(0));
        @(posedge clk); #1;
    endtask

    // Monitor: drives Out_rdy, pops the scoreboard on every output handshake.
    initial begin
        bit           held    = 1'b0;
        bit           post_hs = 1'b0;
        logic [W-1:0] hv      = '0;
        wait (started);
        forever begin
            @(posedge clk); #1;
            if (stall_n > 0 && bus.Out_vld) begin
                bus.Out_rdy = 1'b0;
                stall_n--;
            end else begin
                bus.Out_rdy = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            if (rst) begin
                held    = 1'b0;
                post_hs = 1'b0;
            end else begin
                check("rdy_vld_excl", W'(bus.In_rdy), W'(!bus.Out_vld));
                if (post_hs) check("in_rdy_after_hs", W'(bus.In_rdy), W'(1));
                if (held && bus.Out_vld) check("res_hold", bus.res, hv);
                if (bus.Out_vld && bus.Out_rdy) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out: got res=%b with nothing expected", bus.res);
                    end else begin
                        check("res", bus.res, expq.pop_front());
                    end
                end
                post_hs = bus.Out_vld && bus.Out_rdy;
                held    = bus.Out_vld && !bus.Out_rdy;
                hv      = bus.res;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arr4_t dd, gg;
        int    n;
        bus.x       = 2'b00;
        bus.In_vld  = 1'b0;
        bus.Out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("init_in_rdy", W'(bus.In_rdy), W'(1));
        check("init_out_vld", W'(bus.Out_vld), W'(0));
        check("init_res", bus.res, W'(0));
        started = 1'b1;
        @(posedge clk); #1;

        dd = '{1, 0, -1, 1};   gg = '{0, 0, 0, 0}; send_word(dd, gg, 0);
        dd = '{-1, -1, -1, -1}; gg = '{0, 2, 0, 2}; send_word(dd, gg, 0);
        dd = '{0, 2, 0, 2};    gg = '{0, 0, 0, 0}; send_word(dd, gg, 0);
        dd = '{1, 1, 0, 0};    gg = '{0, 0, 0, 0}; send_word(dd, gg, 3);
        dd = '{1, -1, 1, -1};  gg = '{0, 2, 0, 1}; send_word(dd, gg, 0);
        send_digit(1, 0);
        send_digit(-1, 0);
        do_reset();
        dd = '{1, 1, 1, 1};    gg = '{0, 0, 0, 0}; send_word(dd, gg, 0);
        dd = '{0, 0, 1, -1};   gg = '{0, 0, 0, 0}; send_word(dd, gg, 0);

        repeat (40) begin
            for (int i = 0; i < ND; i++) begin
                dd[i] = int'($urandom_range(0, 3)) - 1;
                gg[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            send_word(dd, gg, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        bus.In_vld = 1'b0;
        n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d words outstanding expected 0", expq.size());
        end
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
